// File: rtl/alu_multicycle_if.sv
// Operation and flag encodings shared by the ALU and its users, plus the
// request/response bundle connecting them.
package alu_ctrl_pkg;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB, OP_SHL, OP_ROL, OP_SHR, OP_ROR,
        OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MUL, OP_DIV
    } alu_op_e;

    typedef enum logic [1:0] {
        FLAG_NONE, FLAG_ZERO, FLAG_CARRY, FLAG_REMAINDER
    } alu_flag_e;
endpackage

interface alu_multicycle_if #(parameter int WIDTH = 8);
    import alu_ctrl_pkg::*;

    logic             in_valid;
    logic             in_ready;
    alu_op_e          op;
    logic [WIDTH-1:0] register1;
    logic [WIDTH-1:0] register2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    alu_flag_e        flag;
    logic             div_by_zero;

    modport master (
        output in_valid, op, register1, register2, out_ready,
        input  in_ready, out_valid, result, result_hi, flag, div_by_zero
    );

    modport slave (
        input  in_valid, op, register1, register2, out_ready,
        output in_ready, out_valid, result, result_hi, flag, div_by_zero
    );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL and
// restoring DIV sharing one accumulator/shift register pair.
module alu_multicycle #(
    parameter int WIDTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    alu_multicycle_if.slave   bus
);
    import alu_ctrl_pkg::*;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    alu_op_e          op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    alu_flag_e        flag_q, flag_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    function automatic alu_flag_e flag_of(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] h,
                                          input logic carry, input logic rem);
        if (r == '0 && h == '0) return FLAG_ZERO;
        else if (carry)         return FLAG_CARRY;
        else if (rem)           return FLAG_REMAINDER;
        else                    return FLAG_NONE;
    endfunction

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        hi_d     = hi_q;
        flag_d   = flag_q;
        dbz_d    = dbz_q;
        sc_res   = '0;
        sc_carry = 1'b0;
        sum      = '0;
        shifted  = '0;
        trial    = '0;

        // Unknown opcodes fall through with sc_res = 0, which flags ZERO.
        case (bus.op)
            OP_ADD: {sc_carry, sc_res} = {1'b0, bus.register1} + {1'b0, bus.register2};
            OP_SUB: sc_res = bus.register1 - bus.register2;
            OP_SHL: sc_res = {bus.register1[WIDTH-2:0], 1'b0};
            OP_ROL: sc_res = {bus.register1[WIDTH-2:0], bus.register1[WIDTH-1]};
            OP_SHR: sc_res = {1'b0, bus.register1[WIDTH-1:1]};
            OP_ROR: sc_res = {bus.register1[0], bus.register1[WIDTH-1:1]};
            OP_AND: sc_res = bus.register1 & bus.register2;
            OP_OR:  sc_res = bus.register1 | bus.register2;
            OP_XOR: sc_res = bus.register1 ^ bus.register2;
            OP_NOT: sc_res = ~bus.register1;
            default: sc_res = '0;
        endcase

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d  = bus.op;
                    opa_d = bus.register1;
                    opb_d = bus.register2;
                    cnt_d = '0;
                    acc_d = '0;
                    if (bus.op == OP_MUL) begin
                        lo_d    = bus.register2;
                        state_d = BUSY;
                    end else if (bus.op == OP_DIV) begin
                        lo_d    = bus.register1;
                        state_d = BUSY;
                    end else begin
                        result_d = sc_res;
                        hi_d     = '0;
                        dbz_d    = 1'b0;
                        flag_d   = flag_of(sc_res, {WIDTH{1'b0}}, sc_carry, 1'b0);
                        state_d  = DONE;
                    end
                end
            end
            BUSY: begin
                if (op_q == OP_MUL) begin
                    sum = acc_q + {1'b0, (lo_q[0] ? opa_q : {WIDTH{1'b0}})};
                    {acc_d, lo_d} = {1'b0, sum, lo_q[WIDTH-1:1]};
                end else begin
                    // Borrow out of the trial subtraction means the divisor didn't fit.
                    shifted = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
                    trial   = shifted - {1'b0, opb_q};
                    if (trial[WIDTH]) begin
                        acc_d = shifted;
                        lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_d = trial;
                        lo_d  = {lo_q[WIDTH-2:0], 1'b1};
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    result_d = lo_d;
                    hi_d     = acc_d[WIDTH-1:0];
                    dbz_d    = 1'b0;
                    if (op_q == OP_DIV && opb_q == '0) begin
                        result_d = '1;
                        hi_d     = opa_q;
                        dbz_d    = 1'b1;
                    end
                    flag_d = flag_of(result_d, hi_d,
                                     op_q == OP_MUL && hi_d != '0,
                                     op_q == OP_DIV && opb_q != '0 && hi_d != '0);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            flag_q   <= FLAG_ZERO;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            flag_q   <= flag_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.result      = result_q;
    assign bus.result_hi   = hi_q;
    assign bus.flag        = flag_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 4..32.
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  alu_op_e  operation, from the control package.
REQ-007 register1  input  WIDTH  operand A.
REQ-008 register2  input  WIDTH  operand B.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  WIDTH  primary result: low product, quotient or single-cycle result.
REQ-012 result_hi  output  WIDTH  MUL high half; DIV remainder; 0 for all other ops.
REQ-013 flag  output  alu_flag_e  status: ZERO, CARRY, REMAINDER or NONE.
REQ-014 div_by_zero  output  1  set when the completed DIV had register2 == 0.

Function
REQ-015 FSM states SHALL be IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Acceptance: in_valid && in_ready at a rising edge; op, register1 and register2 are captured at that edge, and input changes afterwards SHALL be ignored until the next acceptance.
REQ-017 Single-cycle ops (ADD, SUB, SHL, ROL, SHR, ROR, AND, OR, XOR, NOT): IDLE->DONE on acceptance; out_valid SHALL be 1 one cycle after the accepting edge.
REQ-018 MUL: unsigned shift-add, one partial product per cycle; IDLE->BUSY, then BUSY->DONE after WIDTH iterations; out_valid SHALL be 1 exactly WIDTH+1 cycles after the accepting edge.
REQ-019 DIV: unsigned restoring division, one quotient bit per cycle; same state path and latency as MUL.
REQ-020 Arithmetic: ADD SHALL yield {carry, result} = A+B; SUB SHALL yield A-B modulo 2^WIDTH; MUL SHALL yield {result_hi, result} = A*B (2*WIDTH bits); DIV SHALL yield result = A/B and result_hi = A%B.
REQ-021 Shifts and rotates: SHL/SHR are logical shifts by 1 with zero fill; ROL/ROR rotate by 1; all use A only.
REQ-022 DIV with B == 0 SHALL complete with normal DIV latency and give result = all-ones, result_hi = A, div_by_zero = 1, flag = NONE.
REQ-023 An op not listed in REQ-017..REQ-019 SHALL complete as a single-cycle op with result = 0, result_hi = 0, flag = ZERO.
REQ-024 Flag priority:
- ZERO if result == 0 and result_hi == 0;
- else CARRY if ADD had a carry-out or MUL had result_hi != 0;
- else REMAINDER if DIV had result_hi != 0 and B != 0;
- else NONE.
REQ-025 result, result_hi, flag and div_by_zero SHALL be registered, SHALL change only when DONE is entered, and SHALL hold while out_valid && !out_ready.
REQ-026 DONE->IDLE SHALL occur on out_valid && out_ready; out_valid falls at that edge.
REQ-027 in_ready is 0 in DONE, so back-to-back single-cycle ops SHALL sustain one result every 2 cycles at most.
REQ-028 BUSY SHALL ignore in_valid and out_ready.

Reset
REQ-029 Asserting reset SHALL immediately force IDLE, out_valid = 0, result = 0, result_hi = 0, flag = ZERO, div_by_zero = 0, and clear the iteration counter and datapath registers.
REQ-030 Reset asserted during BUSY or DONE SHALL discard the operation in progress with no result delivered.
REQ-031 After reset is released, in_ready SHALL be 1 in the first cycle.

Verification
REQ-032 Directed bench scenarios (WIDTH=8, out_ready=1 unless stated):
- ADD 200+100 -> one cycle later: out_valid=1, result=44, result_hi=0, flag=CARRY.
- MUL 16*16 -> out_valid exactly 9 cycles after accept: result=0, result_hi=1, flag=CARRY; in_ready=0 throughout.
- DIV 100/7 -> after 9 cycles: result=14, result_hi=2, flag=REMAINDER, div_by_zero=0; then DIV 55/0 -> result=255, result_hi=55, flag=NONE, div_by_zero=1.
- Backpressure: SUB 5-5 with out_ready=0 for 4 cycles -> out_valid held, result=0, flag=ZERO stable, in_ready=0; out_ready=1 -> IDLE next edge.
- Reset mid-MUL: assert reset 3 cycles after accepting 255*255 -> outputs immediately at reset values, no out_valid pulse; a new ADD 1+1 after release -> result=2, flag=NONE.
- Input hold: change register1 and op during DIV BUSY -> result matches the captured operands.
